// File: rtl/osc_slot_sequencer.sv
// ---------------------------------------------------------------------------
// osc_slot_sequencer
//
// Master TDM slot scheduler for the oscillator datapath (nco2 + sine lookup).
// A free-running slot counter xxxx = {voice, osc, env} steps once per clock
// while run is high. Per-voice phase-accumulator reset requests are collected
// in a pending set. At each frame wrap that set is moved into osc_accum_zero,
// where it is held for one full frame.
//
// Optional feature macro: SEQ_FRAME_ALIGN_STOP_EN
//   defined     : when run drops mid-frame, the counter finishes the frame,
//                 then parks at slot 0. The final wrap still raises
//                 frame_start and latches pending.
//   not defined : run=0 freezes xxxx at its current value.
//
// Ports
//   sCLK_XVXOSC     in   slot clock
//   reset_data_N    in   asynchronous active-low reset
//   run             in   1 = advance slot counter
//   zero_req        in   single-cycle phase-reset request
//   zero_voice      in   voice targeted by zero_req
//   zero_ack        out  request accepted, one cycle after zero_req
//   xxxx            out  slot index {vx, ox, ex}
//   frame_start     out  one-cycle pulse on the cycle after a wrap to 0
//   osc_accum_zero  out  per-voice accumulator reset, held for one frame
//   zero_pending    out  OR of pending request bits
// ---------------------------------------------------------------------------
module osc_slot_sequencer #(
  parameter int VOICES   = 8,
  parameter int V_ENVS   = 8,
  parameter int V_WIDTH  = 3,
  parameter int O_WIDTH  = 2,
  parameter int OE_WIDTH = 1,
  parameter int E_WIDTH  = O_WIDTH + OE_WIDTH
) (
  input  logic                       sCLK_XVXOSC,
  input  logic                       reset_data_N,
  input  logic                       run,
  input  logic                       zero_req,
  input  logic [V_WIDTH-1:0]         zero_voice,
  output logic                       zero_ack,
  output logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  output logic                       frame_start,
  output logic [V_ENVS-1:0]          osc_accum_zero,
  output logic                       zero_pending
);

  localparam int F_WIDTH = V_WIDTH + E_WIDTH;
  localparam logic [F_WIDTH-1:0] SLOT_ONE = F_WIDTH'(1);

  logic [F_WIDTH-1:0] xxxx_q, xxxx_d;
  logic               frame_start_q;
  logic               zero_ack_q;
  logic [V_ENVS-1:0]  pending_q, pending_d;
  logic [V_ENVS-1:0]  accum_q, accum_d;
  logic               zero_pending_q;
  logic [V_ENVS-1:0]  req_mask;
  logic               advance;
  logic               wrap;

  // One-hot decode of the request. Voices at or above VOICES decode to
  // nothing, so such requests are acknowledged but leave pending unchanged.
  for (genvar gi = 0; gi < V_ENVS; gi++) begin : g_req
    if (gi < VOICES) begin : g_valid
      assign req_mask[gi] = zero_req & (zero_voice == V_WIDTH'(gi));
    end else begin : g_unused
      assign req_mask[gi] = 1'b0;
    end
  end

  always_comb begin
`ifdef SEQ_FRAME_ALIGN_STOP_EN
    // Keep counting until the frame completes, then park at slot 0.
    advance = run | (xxxx_q != '0);
`else
    advance = run;
`endif
    wrap    = advance & (&xxxx_q);
    xxxx_d  = advance ? (xxxx_q + SLOT_ONE) : xxxx_q;
    // A request in the wrap cycle lands in the freshly cleared set. It is
    // applied in the following frame, not this one.
    pending_d = (wrap ? '0 : pending_q) | req_mask;
    accum_d   = wrap ? pending_q : accum_q;
  end

  always_ff @(posedge sCLK_XVXOSC or negedge reset_data_N) begin
    if (!reset_data_N) begin
      xxxx_q         <= '0;
      frame_start_q  <= 1'b0;
      zero_ack_q     <= 1'b0;
      pending_q      <= '0;
      accum_q        <= '0;
      zero_pending_q <= 1'b0;
    end else begin
      xxxx_q         <= xxxx_d;
      frame_start_q  <= wrap;
      zero_ack_q     <= zero_req;
      pending_q      <= pending_d;
      accum_q        <= accum_d;
      zero_pending_q <= |pending_d;
    end
  end

  assign xxxx           = xxxx_q;
  assign frame_start    = frame_start_q;
  assign zero_ack       = zero_ack_q;
  assign osc_accum_zero = accum_q;
  assign zero_pending   = zero_pending_q;

endmodule
